// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full adder walks operands LSB first over WIDTH cycles,
// publishing sum and carry-out only when the last bit has been processed.

module full_adder (
  input  logic i_x,
  input  logic i_y,
  input  logic i_carry,
  output logic o_sum,
  output logic o_carry
);
  assign o_sum   = i_x ^ i_y ^ i_carry;
  assign o_carry = (i_x & i_y) | (i_x & i_carry) | (i_y & i_carry);
endmodule

module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;

  logic fa_sum;
  logic fa_carry;

  full_adder u_fa (
    .i_x     (a_reg[0]),
    .i_y     (b_reg[0]),
    .i_carry (carry_reg),
    .o_sum   (fa_sum),
    .o_carry (fa_carry)
  );

  // Full result as it will look once the current adder bit is shifted in.
  logic [WIDTH-1:0] res_next;
  assign res_next = {fa_sum, res_reg[WIDTH-1:1]};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (i_start) begin
            a_reg     <= i_a;
            b_reg     <= i_b;
            carry_reg <= i_cin;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end else begin
            state_reg <= IDLE;
          end
        end
        RUN: begin
          res_reg   <= res_next;
          carry_reg <= fa_carry;
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          cnt_reg   <= cnt_reg + 1'b1;
          // Leave on the last bit, so counter wrap never adds a cycle.
          if (cnt_reg == LAST) begin
            sum_reg   <= res_next;
            cout_reg  <= fa_carry;
            state_reg <= DONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign o_busy = (state_reg == RUN);
  assign o_done = (state_reg == DONE);
  assign o_sum  = sum_reg;
  assign o_cout = cout_reg;
endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  synchronous reset, active-high.
REQ-004 i_start  input  1  request a new addition; sampled on rising edge.
REQ-005 i_a  input  WIDTH  operand A; captured when i_start is accepted.
REQ-006 i_b  input  WIDTH  operand B; captured when i_start is accepted.
REQ-007 i_cin  input  1  carry-in; captured when i_start is accepted.
REQ-008 o_busy  output  1  high while an addition is in progress (RUN state).
REQ-009 o_done  output  1  one-cycle pulse marking o_sum/o_cout as newly valid.
REQ-010 o_sum  output  WIDTH  registered result of the last completed addition.
REQ-011 o_cout  output  1  registered carry-out of the last completed addition.

Function
REQ-012 The block SHALL compute i_a+i_b+i_cin bit-serially, LSB first, using exactly one full_adder instance (i_x, i_y, i_carry, o_sum, o_carry); no other addition logic.
REQ-013 FSM states SHALL be IDLE, RUN and DONE.
REQ-014 IDLE: o_busy=0, o_done=0; i_start=1 captures i_a, i_b and i_cin into internal A/B shift registers and the carry flip-flop, clears the bit counter, and moves to RUN.
REQ-015 RUN: each cycle feeds A[0], B[0] and the carry flip-flop to the full adder; the sum bit shifts into the MSB of the internal result shift register; the carry flip-flop loads the adder carry; A and B shift right by one; the counter increments.
REQ-016 RUN SHALL last exactly WIDTH cycles; on the edge that processes bit WIDTH-1, the full result SHALL load into o_sum, the final carry into o_cout, o_done SHALL set, and the FSM SHALL move to DONE.
REQ-017 Latency: o_done SHALL be high in the cycle that begins WIDTH rising edges after the edge that accepted i_start; o_busy SHALL be high for exactly those WIDTH cycles.
REQ-018 DONE: o_done=1 for exactly one cycle; the FSM returns to IDLE unless i_start=1, which is accepted exactly as in IDLE (back-to-back operation, no idle gap).
REQ-019 i_start during RUN SHALL be ignored, with no effect on operands, counter or outputs.
REQ-020 o_sum and o_cout SHALL stay stable from one completion until the next completion or reset; partial results SHALL never appear on them.
REQ-021 Operands SHALL be captured only at acceptance; i_a/i_b/i_cin changes during RUN SHALL NOT affect the result.
REQ-022 Result arithmetic SHALL be modulo 2^WIDTH, with overflow reported only in o_cout.
REQ-023 The counter width SHALL be ceil(log2(WIDTH)); for WIDTH a power of two, counter wrap SHALL NOT cause an extra or missing cycle.

Reset
REQ-024 i_rst=1 at a rising edge SHALL force IDLE and clear o_busy, o_done, o_sum, o_cout, the counter, the carry flip-flop and all shift registers to 0.
REQ-025 Reset SHALL take priority over i_start and abort any addition in progress, with no o_done pulse.

Verification (WIDTH=8)
REQ-026 Hold i_rst for 2 cycles, then release -> o_busy=0, o_done=0, o_sum=0x00, o_cout=0.
REQ-027 Start with a=0x35, b=0x4A, cin=0 -> o_busy high for 8 cycles; o_done pulses once on the 8th edge after acceptance; o_sum=0x7F, o_cout=0.
REQ-028 Start with a=0xFF, b=0x01, cin=0 -> o_sum=0x00, o_cout=1; then a=0xFF, b=0xFF, cin=1 -> o_sum=0xFF, o_cout=1.
REQ-029 Start with a=0x10, b=0x20; pulse i_start with a=0xAA during RUN cycle 3 -> pulse ignored, result 0x30.
REQ-030 Hold i_start=1 in the DONE cycle with a=0x01, b=0x02 -> next RUN begins immediately; after the first o_done, o_sum=0x03 eight edges later; the prior result stays stable in between.
REQ-031 Assert i_rst in RUN cycle 4 of a=0x0F, b=0x01 -> next cycle IDLE with all outputs 0 and no o_done; a following a=0x0F, b=0x01 -> o_sum=0x10, o_cout=0.
